// File: rtl/hack_rom_loader.sv
// UART 8N1 boot loader: length-prefixed big-endian image into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module hack_rom_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 15,
  parameter int INST_W       = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [INST_W-1:0] imem_data_o,
  output logic              core_reset_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] T_ONE  = CW'(1);
  localparam logic [CW-1:0] T_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] T_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0] MAX_LEN  = 17'(1) << ADDR_W;

  typedef enum logic [1:0] {
    U_IDLE, U_START, U_DATA, U_STOP
  } ustate_t;

  typedef enum logic [2:0] {
    L_LEN_HI, L_LEN_LO, L_DATA_HI, L_DATA_LO,
    L_CSUM, L_DONE, L_ERR
  } lstate_t;

`ifdef LOADER_CHECKSUM_EN
  localparam lstate_t L_FIN = L_CSUM;
`else
  localparam lstate_t L_FIN = L_DONE;
`endif

  ustate_t     us_q;
  logic        rx_s1_q;
  logic        rx_s2_q;
  logic        rx_prev_q;
  logic [CW-1:0] tick_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;
  logic        bv_q;
  logic        fe_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      us_q      <= U_IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      tick_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      bv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      bv_q      <= 1'b0;
      fe_q      <= 1'b0;
      unique case (us_q)
        U_IDLE: begin
          if (!rx_s2_q && rx_prev_q) begin
            us_q   <= U_START;
            tick_q <= '0;
          end
        end
        U_START: begin
          if (tick_q == T_HALF) begin
            tick_q <= '0;
            bit_q  <= '0;
            // a line back high mid-start-bit is a glitch
            us_q   <= rx_s2_q ? U_IDLE : U_DATA;
          end else begin
            tick_q <= tick_q + T_ONE;
          end
        end
        U_DATA: begin
          if (tick_q == T_FULL) begin
            tick_q <= '0;
            sh_q   <= {rx_s2_q, sh_q[7:1]};
            bit_q  <= bit_q + 3'd1;
            if (bit_q == 3'd7) us_q <= U_STOP;
          end else begin
            tick_q <= tick_q + T_ONE;
          end
        end
        U_STOP: begin
          if (tick_q == T_FULL) begin
            tick_q <= '0;
            us_q   <= U_IDLE;
            bv_q   <= rx_s2_q;
            fe_q   <= !rx_s2_q;
          end else begin
            tick_q <= tick_q + T_ONE;
          end
        end
        default: us_q <= U_IDLE;
      endcase
    end
  end

  lstate_t           ls_q;
  logic [15:0]       len_q;
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] idx_q;
  logic [7:0]        csum_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] data_q;
  logic              core_rst_q;
  logic              done_q;
  logic              err_q;

  logic [15:0] len_nx;
  logic        last_w;

  assign len_nx = {len_q[15:8], sh_q};
  assign last_w = (17'(idx_q) + 17'd1) == {1'b0, len_q};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ls_q       <= L_LEN_HI;
      len_q      <= '0;
      hi_q       <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (fe_q && ls_q != L_DONE) begin
        ls_q <= L_ERR;
      end else if (bv_q) begin
        unique case (ls_q)
          L_LEN_HI: begin
            len_q[15:8] <= sh_q;
            ls_q        <= L_LEN_LO;
          end
          L_LEN_LO: begin
            len_q[7:0] <= sh_q;
            idx_q      <= '0;
            csum_q     <= '0;
            if (len_nx == 16'd0)
              ls_q <= L_FIN;
            else if ({1'b0, len_nx} > MAX_LEN)
              ls_q <= L_ERR;
            else
              ls_q <= L_DATA_HI;
          end
          L_DATA_HI: begin
            hi_q   <= sh_q;
            csum_q <= csum_q ^ sh_q;
            ls_q   <= L_DATA_LO;
          end
          L_DATA_LO: begin
            we_q   <= 1'b1;
            addr_q <= idx_q;
            data_q <= INST_W'({hi_q, sh_q});
            idx_q  <= idx_q + ADDR_W'(1);
            csum_q <= csum_q ^ sh_q;
            ls_q   <= last_w ? L_FIN : L_DATA_HI;
          end
`ifdef LOADER_CHECKSUM_EN
          L_CSUM: begin
            ls_q <= (sh_q == csum_q) ? L_DONE : L_ERR;
          end
`endif
          default: ;
        endcase
      end
      // outputs trail the state by one cycle
      core_rst_q <= (ls_q != L_DONE);
      done_q     <= (ls_q == L_DONE);
      err_q      <= (ls_q == L_ERR);
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_data_o  = data_q;
  assign core_reset_o = core_rst_q;
  assign done_o       = done_q;
  assign error_o      = err_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Bench for hack_rom_loader: directed and random images vs. an image-level model.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_hack_rom_loader;

  localparam int C   = 16;
  localparam int LAT = 4 + C / 2 + 9 * C;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        we;
  logic [14:0] addr;
  logic [15:0] data;
  logic        core_rst;
  logic        done;
  logic        err;

  hack_rom_loader #(
    .CLKS_PER_BIT(C),
    .ADDR_W(15),
    .INST_W(16)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .rx_i(rx),
    .imem_we_o(we),
    .imem_addr_o(addr),
    .imem_data_o(data),
    .core_reset_o(core_rst),
    .done_o(done),
    .error_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  typedef struct {
    int addr;
    int data;
    int cyc;
    int rst;
  } wr_t;

  typedef struct {
    int addr;
    int data;
    int lo;
  } ex_t;

  wr_t        wr_q[$];
  ex_t        ex_q[$];
  int         st_q[$];
  logic [7:0] img_q[$];
  int         fe_pos;

  always @(negedge clk)
    if (we)
      wr_q.push_back('{int'(addr), int'(data), cyc, int'(core_rst)});

  task automatic send_byte(input logic [7:0] b,
                           input bit stop_ok,
                           input int gap);
    @(posedge clk);
    #1;
    st_q.push_back(cyc);
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (C) @(posedge clk);
    #1 rx = stop_ok;
    repeat (C) @(posedge clk);
    #1 rx = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic model(output bit e_done, output bit e_err);
    int n;
    int len;
    int need;
    logic [7:0] x;
    ex_q.delete();
    e_done = 1'b0;
    e_err  = 1'b0;
    n = img_q.size();
    if (fe_pos == 0 || fe_pos == 1) begin
      e_err = 1'b1;
      return;
    end
    if (n < 2) return;
    len = {img_q[0], img_q[1]};
    if (len > 32768) begin
      e_err = 1'b1;
      return;
    end
    need = 2 + 2 * len + (CS ? 1 : 0);
    for (int k = 0; k < len; k++) begin
      int lo;
      lo = 3 + 2 * k;
      if (lo < n && (fe_pos < 0 || lo < fe_pos))
        ex_q.push_back('{k, {img_q[lo-1], img_q[lo]}, lo});
    end
    if (fe_pos >= 0 && fe_pos < need) begin
      e_err = 1'b1;
    end else if (n >= need) begin
      if (CS) begin
        x = 8'h00;
        for (int i = 2; i < need - 1; i++) x ^= img_q[i];
        if (x == img_q[need-1]) e_done = 1'b1;
        else e_err = 1'b1;
      end else begin
        e_done = 1'b1;
      end
    end
  endtask

  task automatic run_image(input string tag,
                           input bit do_reset,
                           input bit glitch);
    bit e_done;
    bit e_err;
    int nc;
    if (do_reset) begin
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
    end
    wr_q.delete();
    st_q.delete();
    if (glitch) begin
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx = 1'b1;
      repeat (2 * C) @(posedge clk);
      @(negedge clk);
      check({tag, ".glitch_wr"}, wr_q.size(), 0);
      check({tag, ".glitch_err"}, err, 0);
    end
    foreach (img_q[i])
      send_byte(img_q[i], i != fe_pos, $urandom_range(0, 4));
    repeat (3 * C) @(posedge clk);
    @(negedge clk);
    model(e_done, e_err);
    check({tag, ".nwr"}, wr_q.size(), ex_q.size());
    nc = (wr_q.size() < ex_q.size()) ? wr_q.size() : ex_q.size();
    for (int k = 0; k < nc; k++) begin
      check({tag, ".addr"}, wr_q[k].addr, ex_q[k].addr);
      check({tag, ".data"}, wr_q[k].data, ex_q[k].data);
      check({tag, ".lat"}, wr_q[k].cyc - st_q[ex_q[k].lo], LAT);
      check({tag, ".rst_at_wr"}, wr_q[k].rst, 1);
    end
    check({tag, ".done"}, done, e_done);
    check({tag, ".err"}, err, e_err);
    check({tag, ".core_rst"}, core_rst, !e_done);
    if (ex_q.size() > 0) begin
      check({tag, ".addr_hold"}, addr, ex_q[ex_q.size()-1].addr);
      check({tag, ".data_hold"}, data, ex_q[ex_q.size()-1].data);
    end else begin
      check({tag, ".addr_idle"}, addr, 0);
      check({tag, ".data_idle"}, data, 0);
    end
  endtask

  initial begin
    int len;
    int nw;
    logic [15:0] w;
    logic [15:0] lv;
    logic [7:0] x;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.we", we, 0);
    check("rst.addr", addr, 0);
    check("rst.data", data, 0);
    check("rst.core_rst", core_rst, 1);
    check("rst.done", done, 0);
    check("rst.err", err, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    img_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    if (CS) img_q.push_back(8'h40);
    fe_pos = -1;
    run_image("two_words", 1'b1, 1'b0);

    img_q = {8'h00, 8'h00};
    if (CS) img_q.push_back(8'h00);
    run_image("zero_len", 1'b1, 1'b0);

    img_q = {8'h80, 8'h01, 8'h00, 8'h01, 8'h12, 8'h34};
    run_image("too_long", 1'b1, 1'b0);

    img_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    fe_pos = 3;
    run_image("frame_err", 1'b1, 1'b0);

    img_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    if (CS) img_q.push_back(8'h40);
    fe_pos = -1;
    run_image("after_err", 1'b1, 1'b0);

    run_image("glitch", 1'b1, 1'b1);

    img_q = {8'h00, 8'h02, 8'h55, 8'h66, 8'h77};
    foreach (img_q[i]) send_byte(img_q[i], 1'b1, 2);
    img_q = {8'h00, 8'h01, 8'hBE, 8'hEF};
    if (CS) img_q.push_back(8'hBE ^ 8'hEF);
    run_image("mid_reset", 1'b1, 1'b0);

    if (CS) begin
      img_q = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
      run_image("bad_csum", 1'b1, 1'b0);
    end

    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 5) == 0) len = $urandom_range(32769, 65535);
      else len = $urandom_range(0, 3);
      lv = 16'(len);
      img_q = {lv[15:8], lv[7:0]};
      nw = (len > 32768) ? 2 : len;
      x = 8'h00;
      for (int k = 0; k < nw; k++) begin
        w = 16'($urandom);
        img_q.push_back(w[15:8]);
        img_q.push_back(w[7:0]);
        x ^= w[15:8] ^ w[7:0];
      end
      if (CS) img_q.push_back(($urandom_range(0, 3) == 0) ? x ^ 8'h01 : x);
      if ($urandom_range(0, 1) == 1) img_q.push_back(8'($urandom));
      if ($urandom_range(0, 2) == 0)
        fe_pos = $urandom_range(0, img_q.size() - 1);
      else
        fe_pos = -1;
      run_image($sformatf("rand%0d", t), 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Boot-time stage directly upstream of the instruction memory and CPU core.
- Receives a program image over a UART serial line (8N1) and assembles it into 16-bit instruction words.
- Writes each word sequentially into the writable instruction memory.
- Holds the core in reset until the whole image has been loaded, then releases it.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be >= 4.
- ADDR_W, 15, instruction address width.
- INST_W, 16, instruction width; fixed at 16 by the protocol.

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- rx_i  input  1  UART receive line; idles high; asynchronous to clk_i
- imem_we_o  output  1  instruction memory write strobe, one-cycle pulse per word
- imem_addr_o  output  ADDR_W  instruction write address
- imem_data_o  output  INST_W  instruction write data
- core_reset_o  output  1  held high until the load completes successfully
- done_o  output  1  load completed successfully; sticky
- error_o  output  1  load failed; sticky

Behaviour:
- Clocking and reset:
  - One clock, clk_i. reset_i is synchronous and active-high.
  - Reset values: imem_we_o=0, imem_addr_o=0, imem_data_o=0, core_reset_o=1, done_o=0, error_o=0.
  - Reset state: FSM in LEN_HI, UART receiver idle, word counter 0.
  - reset_i asserted mid-load aborts the load. The next image starts again from LEN_HI. Memory already written is not cleared.
- UART receiver:
  - rx_i passes through a 2-flop synchronizer, reset to 1.
  - A start is detected when the synchronized line goes 1->0 while the receiver is idle.
  - Start bit is re-sampled at CLKS_PER_BIT/2. If it reads 1, the event is a glitch: return to idle, no byte, no error.
  - Data bits are sampled LSB first, every CLKS_PER_BIT after the start sample.
  - Stop bit is sampled once. If 1, a one-cycle byte_valid pulse is emitted. If 0, a framing error is raised.
  - After the stop sample the receiver returns to idle immediately, ready for the next start edge.
- Load FSM (advances on byte_valid; all multi-byte fields are big-endian):
  - LEN_HI: latch count[15:8] -> LEN_LO.
  - LEN_LO: latch count[7:0].
    - count == 0 -> DONE (or CSUM if the optional feature is enabled).
    - count > 2^ADDR_W -> ERR.
    - otherwise -> DATA_HI.
  - DATA_HI: latch hi byte -> DATA_LO.
  - DATA_LO: in the cycle after byte_valid, pulse imem_we_o with imem_data_o={hi,lo} and imem_addr_o=word index.
    - Increment the word index.
    - Last word (index == count-1) -> DONE (or CSUM). Otherwise -> DATA_HI.
  - DONE: core_reset_o deasserts the cycle after entry; done_o=1. All further rx traffic is ignored.
  - ERR: error_o=1, core_reset_o stays 1. Exit only via reset_i.
- Boundary conditions:
  - Address wrap cannot occur: count is bounded at 2^ADDR_W.
  - A framing error in any state except DONE goes to ERR.
  - imem_addr_o and imem_data_o hold their last values between strobes.
- Latency: the write strobe follows the stop-bit sample of the low byte by exactly 1 cycle.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A CSUM state follows the last word, or LEN_LO when count == 0.
  - The next received byte is compared with the running XOR of every byte after the length field; the length bytes are excluded.
  - Match -> DONE. Mismatch -> ERR.
  - A mismatch does not retract writes already made.
- Undefined: no CSUM state; completion follows the last word (or count == 0) directly.

Test Plan:
- Image with count=0x0002, words 0x1234 and 0xABCD (no checksum) -> two imem_we_o pulses: (addr 0, 0x1234) then (addr 1, 0xABCD). Strobe 1 cycle after the stop sample. core_reset_o falls and done_o=1 right after the second write.
- count=0x0000 -> no writes, done_o=1, core_reset_o=0. With LOADER_CHECKSUM_EN, only after checksum byte 0x00.
- count=0x8001 (ADDR_W=15) -> error_o=1, core_reset_o=1, no writes. Further bytes ignored until reset_i.
- Stop bit driven 0 on the second data byte -> error_o=1, exactly one byte latched and no write issued. Then assert reset_i for 1 cycle and resend a valid image -> loads normally from address 0.
- 3-cycle low glitch on rx_i while idle (CLKS_PER_BIT=16) -> no byte_valid, state unchanged.
- LOADER_CHECKSUM_EN, words 0x1234 and 0xABCD:
  - checksum 0x12^0x34^0xAB^0xCD = 0x40 -> done_o=1.
  - checksum 0x41 -> error_o=1 and core_reset_o stays 1.
